// File: rtl/regfile_pkg.sv
// regfile_pkg: items shared by the multi-port register file and its
// scoreboard.
//   XLEN_DEF / NREG_DEF : default data width and architectural register count
//   ZERO_REG            : index of the hardwired-zero register
//   slice_lo()          : low bit of lane idx in a flattened multi-port bus
package regfile_pkg;

  localparam int XLEN_DEF = 32;
  localparam int NREG_DEF = 32;
  localparam int ZERO_REG = 0;

  // Port idx of a flattened bus occupies bits [slice_lo(idx, width) +: width].
  function automatic int slice_lo(input int idx, input int width);
    return idx * width;
  endfunction

endpackage

// File: rtl/regfile_sb.sv
// regfile_sb: busy scoreboard for the register file.
// Issue sets a destination busy. A clearing writeback makes it idle again.
// Set wins over a same-cycle clear, because the newly issued producer
// supersedes the one that is retiring.
//   clk, rst_n : clock and asynchronous active-low reset
//   wr_en      : NWR write enables (a clear needs wr_en as well as wr_clr)
//   wr_addr    : NWR*AW write addresses
//   wr_clr     : NWR clear-busy requests that travel with the writes
//   sb_set     : issue strobe; marks sb_addr busy
//   sb_addr    : register being issued
//   busy       : current busy vector; bit ZERO_REG is always 0
//   clr_now    : registers that this edge clears (clear present, no set)
//   busy_cnt   : registered popcount of the post-edge busy vector
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int NREG = NREG_DEF,
  parameter int NWR  = 1,
  parameter int AW   = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic [NWR-1:0]      wr_en,
  input  logic [NWR*AW-1:0]   wr_addr,
  input  logic [NWR-1:0]      wr_clr,
  input  logic                sb_set,
  input  logic [AW-1:0]       sb_addr,
  output logic [NREG-1:0]     busy,
  output logic [NREG-1:0]     clr_now,
  output logic [AW:0]         busy_cnt
);

  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;
  logic [NREG-1:0] busy_next;
  logic [AW:0]     cnt_next;

  // NOTE: each always_comb variable gets a default on its first line. Any
  // path that leaves a variable unassigned would otherwise infer a latch.
  always_comb begin
    set_vec = '0;
    clr_vec = '0;
    if (sb_set && (sb_addr != AW'(ZERO_REG))) set_vec[sb_addr] = 1'b1;
    for (int j = 0; j < NWR; j++) begin
      if (wr_en[j] && wr_clr[j]) clr_vec[wr_addr[slice_lo(j, AW) +: AW]] = 1'b1;
    end
    clr_vec[ZERO_REG] = 1'b0;
  end

  assign clr_now   = clr_vec & ~set_vec;
  assign busy_next = (busy | set_vec) & ~clr_now;

  always_comb begin
    cnt_next = '0;
    for (int r = 1; r < NREG; r++) cnt_next = cnt_next + (AW + 1)'(busy_next[r]);
  end

  // NOTE: use non-blocking assignments for state so that every flop samples
  // the pre-edge values, whatever order the statements appear in.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy     <= '0;
      busy_cnt <= '0;
    end else begin
      busy     <= busy_next;
      busy_cnt <= cnt_next;
    end
  end

endmodule

// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-port integer register file. It has
// optional same-cycle write-to-read bypass and a built-in busy scoreboard.
//   clk, rst_n : clock and asynchronous active-low reset
//   rd_addr    : NRD*AW read addresses, port i at [i*AW +: AW]
//   rd_data    : NRD*XLEN combinational read data
//   rd_busy    : NRD flags, set when the read register has a pending producer
//   wr_en      : NWR write enables
//   wr_addr    : NWR*AW write addresses
//   wr_data    : NWR*XLEN write data
//   wr_clr     : NWR flags; the write also clears the busy bit of its address
//   sb_set     : issue strobe; marks sb_addr busy
//   sb_addr    : destination being issued
//   busy_cnt   : registered count of busy registers (register 0 excluded)
module regfile_mp
  import regfile_pkg::*;
#(
  parameter int XLEN   = XLEN_DEF,
  parameter int NREG   = NREG_DEF,
  parameter int NRD    = 2,
  parameter int NWR    = 1,
  parameter int BYPASS = 1,
  localparam int AW    = $clog2(NREG)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NRD*AW-1:0]    rd_addr,
  output logic [NRD*XLEN-1:0]  rd_data,
  output logic [NRD-1:0]       rd_busy,
  input  logic [NWR-1:0]       wr_en,
  input  logic [NWR*AW-1:0]    wr_addr,
  input  logic [NWR*XLEN-1:0]  wr_data,
  input  logic [NWR-1:0]       wr_clr,
  input  logic                 sb_set,
  input  logic [AW-1:0]        sb_addr,
  output logic [AW:0]          busy_cnt
);

  logic [NREG-1:0][XLEN-1:0] rf;
  logic [NREG-1:0]           busy;
  logic [NREG-1:0]           clr_now;

  assign rf[ZERO_REG] = '0;

  for (genvar r = 1; r < NREG; r++) begin : g_reg
    logic            hit;
    logic [XLEN-1:0] val;
    logic [XLEN-1:0] q;

    // A later port overwrites an earlier match, so the highest index wins.
    always_comb begin
      hit = 1'b0;
      val = '0;
      for (int j = 0; j < NWR; j++) begin
        if (wr_en[j] && (wr_addr[slice_lo(j, AW) +: AW] == AW'(r))) begin
          hit = 1'b1;
          val = wr_data[slice_lo(j, XLEN) +: XLEN];
        end
      end
    end

    // NOTE: every word has an asynchronous reset. That makes this storage
    // a bank of flops, not an inferred RAM. The reset behaviour needs it.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)   q <= '0;
      else if (hit) q <= val;
    end

    assign rf[r] = q;
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [AW-1:0]   ra;
    logic [XLEN-1:0] data;
    logic            bsy;

    assign ra = rd_addr[slice_lo(i, AW) +: AW];

    always_comb begin
      data = rf[ra];
      if (BYPASS != 0) begin
        for (int j = 0; j < NWR; j++) begin
          if (wr_en[j] && (wr_addr[slice_lo(j, AW) +: AW] == ra) && (ra != AW'(ZERO_REG)))
            data = wr_data[slice_lo(j, XLEN) +: XLEN];
        end
      end
      // Writes driven while the file is in reset must not leak through the bypass.
      if (!rst_n) data = '0;
    end

    // A clearing write in this cycle lets decode take the bypassed value without stalling.
    always_comb begin
      bsy = busy[ra];
      if ((BYPASS != 0) && clr_now[ra]) bsy = 1'b0;
      if (!rst_n) bsy = 1'b0;
    end

    assign rd_data[slice_lo(i, XLEN) +: XLEN] = data;
    assign rd_busy[i] = bsy;
  end

  regfile_sb #(
    .NREG (NREG),
    .NWR  (NWR),
    .AW   (AW)
  ) u_sb (
    .clk      (clk),
    .rst_n    (rst_n),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_clr   (wr_clr),
    .sb_set   (sb_set),
    .sb_addr  (sb_addr),
    .busy     (busy),
    .clr_now  (clr_now),
    .busy_cnt (busy_cnt)
  );

endmodule
